// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: burst, response and write-FSM types shared by the AXI memory
// write slave, its channel FIFOs and the read side.
package axi_mem_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
  typedef enum logic [1:0] {OKAY = RESP_OKAY, SLVERR = RESP_SLVERR, DECERR = RESP_DECERR} resp_t;
  typedef enum logic [1:0] {IDLE, DATA, RESP} wr_state_t;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
endpackage

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat byte address for FIXED/INCR/WRAP bursts.
// Wrap-window logic exists only when AXI_WR_WRAP_EN is defined.
module axi_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int STRB_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  burst_t            burst,
  output logic [ADDR_W-1:0] next_addr
);
  localparam int OFF = $clog2(STRB_W);
  logic [ADDR_W-1:0] incr;
  assign incr = addr + ADDR_W'(STRB_W);
`ifdef AXI_WR_WRAP_EN
  logic [ADDR_W-1:0] mask;
  // window is (len+1) beats wide; the incremented offset stays inside it
  assign mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFF) - ADDR_W'(1);
  always_comb next_addr = burst == INCR ? incr : burst == WRAP ? (addr & ~mask) | (incr & mask) : addr;
`else
  logic unused_len;
  assign unused_len = ^len;
  always_comb next_addr = burst == INCR ? incr : addr;
`endif
endmodule

// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI-style write target committing strobed bursts into a word memory,
// with a registered sideband read port. WRAP bursts honoured only with AXI_WR_WRAP_EN.
module axi_wr_slave
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256,
  localparam int STRB_W   = DATA_W / 8,
  localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [1:0]        aw_burst,
  input  logic [ID_W-1:0]   aw_id,
  input  logic              aw_val,
  output logic              aw_rdy,
  input  logic [DATA_W-1:0] w_data,
  input  logic [STRB_W-1:0] w_strb,
  input  logic              w_last,
  input  logic              w_val,
  output logic              w_rdy,
  output logic [1:0]        b_resp,
  output logic [ID_W-1:0]   b_id,
  output logic              b_val,
  input  logic              b_rdy,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int OFF = $clog2(STRB_W);
  wr_state_t state_q, state_d;
  burst_t burst_q, burst_d;
  resp_t err_q, err_d, b_resp_q, b_resp_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d, b_id_q, b_id_d;
  logic aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, b_val_q, b_val_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-OFF-1:0] word_idx;
  logic bad_burst, in_range, last_beat, w_hs, we;

  axi_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_addr_gen (
    .addr(addr_q), .len(len_q), .burst(burst_q), .next_addr(next_addr)
  );

  assign word_idx  = addr_q[ADDR_W-1:OFF];
  assign in_range  = int'(word_idx) < MEM_DEPTH;
  assign last_beat = cnt_q == len_q;
  assign w_hs      = w_rdy_q && w_val;
`ifdef AXI_WR_WRAP_EN
  assign bad_burst = burst_q == RSVD || (burst_q == WRAP && !wrap_len_ok(len_q));
`else
  assign bad_burst = burst_q == RSVD || burst_q == WRAP;
`endif
  // rejected bursts are drained but never touch memory
  assign we = w_hs && !bad_burst && in_range;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (aw_rdy_q && aw_val) begin
      state_d = DATA;
      addr_d  = aw_addr;
      len_d   = aw_len;
      burst_d = burst_t'(aw_burst);
      id_d    = aw_id;
      cnt_d   = '0;
      err_d   = OKAY;
    end
    if (w_hs) begin
      state_d = last_beat ? RESP : DATA;
      addr_d  = next_addr;
      cnt_d   = cnt_q + 8'd1;
      err_d   = (err_q == DECERR || (!bad_burst && !in_range)) ? DECERR :
                (bad_burst || w_last != last_beat) ? SLVERR : err_q;
    end
    if (b_val_q && b_rdy) state_d = IDLE;
    aw_rdy_d  = state_d == IDLE;
    w_rdy_d   = state_d == DATA;
    b_val_d   = state_d == RESP;
    b_resp_d  = err_d;
    b_id_d    = id_d;
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= FIXED;
      id_q      <= '0;
      cnt_q     <= '0;
      err_q     <= OKAY;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      b_val_q   <= 1'b0;
      b_resp_q  <= OKAY;
      b_id_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aw_rdy_q  <= aw_rdy_d;
      w_rdy_q   <= w_rdy_d;
      b_val_q   <= b_val_d;
      b_resp_q  <= b_resp_d;
      b_id_q    <= b_id_d;
      rd_data_q <= rd_data_d;
    end
  end

  // memory is deliberately outside the reset domain
  always_ff @(posedge clk)
    for (int i = 0; i < STRB_W; i++)
      if (we && w_strb[i]) mem[IDX_W'(word_idx)][i*8 +: 8] <= w_data[i*8 +: 8];

  assign aw_rdy  = aw_rdy_q;
  assign w_rdy   = w_rdy_q;
  assign b_val   = b_val_q;
  assign b_resp  = b_resp_q;
  assign b_id    = b_id_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_axi_wr_slave.sv
// tb_axi_wr_slave: randomized and directed bursts against a byte-level memory model;
// expected B responses are queued at issue and popped by an independent monitor.
module tb_axi_wr_slave;
`ifdef AXI_WR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic [15:0] aw_addr = 0;
  logic [7:0] aw_len = 0, rd_addr = 0;
  logic [1:0] aw_burst = 0, b_resp;
  logic [3:0] aw_id = 0, w_strb = 0, b_id;
  logic aw_val = 0, aw_rdy, w_last = 0, w_val = 0, w_rdy, b_val, b_rdy = 0;
  logic [31:0] w_data = 0, rd_data;
  logic [31:0] mdl [256];
  logic [31:0] bd [256];
  logic [3:0] bs [256];
  logic [5:0] exp_q [$];
  bit b_hold = 0;
  int n_chk = 0, n_fail = 0;

  axi_wr_slave dut (
    .clk(clk), .rst(rst), .aw_addr(aw_addr), .aw_len(aw_len), .aw_burst(aw_burst),
    .aw_id(aw_id), .aw_val(aw_val), .aw_rdy(aw_rdy), .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last), .w_val(w_val), .w_rdy(w_rdy), .b_resp(b_resp), .b_id(b_id),
    .b_val(b_val), .b_rdy(b_rdy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // B-channel monitor: drives b_rdy, checks hold-while-stalled and scoreboard order
  initial begin
    logic pv, ph;
    logic [1:0] pr;
    logic [3:0] pi;
    logic [5:0] e;
    pv = 0; ph = 0; pr = 0; pi = 0;
    forever begin
      @(negedge clk);
      b_rdy = !b_hold && ($urandom_range(0, 3) != 0);
      #1;
      if (pv && !ph && rst) begin
        chk("b_hold_val", b_val, 1);
        chk("b_hold_payload", {b_id, b_resp}, {pi, pr});
      end
      ph = b_val && b_rdy && rst;
      if (ph) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got id %0h resp %0h expected no response", b_id, b_resp);
        end else begin
          e = exp_q.pop_front();
          chk("b_id", b_id, e[5:2]);
          chk("b_resp", b_resp, e[1:0]);
        end
      end
      pv = b_val; pr = b_resp; pi = b_id;
    end
  end

  // Model: per-beat byte addresses from burst rules, strobed writes, sticky errors.
  task automatic burst(input logic [15:0] a, input logic [7:0] len, input logic [1:0] bt,
                       input logic [3:0] id, input int last_at);
    bit bad, dec, slv;
    int ba, sz, base, w, t, L;
    L = int'(len);
    bad = bt == 2'd3 || (bt == 2'd2 && !(WRAP_EN && (L == 1 || L == 3 || L == 7 || L == 15)));
    dec = 0; slv = 0;
    for (int k = 0; k <= L; k++) begin
      sz = (L + 1) * 4;
      base = int'(a) - int'(a) % sz;
      ba = bt == 2'd1 ? (int'(a) + k * 4) % 65536 : bt == 2'd2 ? base + (int'(a) - base + k * 4) % sz : int'(a);
      w = ba / 4;
      if (!bad && w >= 256) dec = 1;
      if (bad || ((k == last_at) != (k == L))) slv = 1;
      if (!bad && w < 256)
        for (int j = 0; j < 4; j++) if (bs[k][j]) mdl[w][j*8 +: 8] = bd[k][j*8 +: 8];
    end
    exp_q.push_back({id, dec ? 2'b11 : slv ? 2'b10 : 2'b00});
    @(negedge clk);
    aw_addr = a; aw_len = len; aw_burst = bt; aw_id = id; aw_val = 1;
    t = 0;
    while (!aw_rdy && t < 200) begin @(negedge clk); t++; end
    chk("aw_wait", t < 200, 1);
    @(negedge clk);
    aw_val = 0;
    chk("w_rdy_latency", w_rdy, 1);
    for (int k = 0; k <= L; k++) begin
      repeat ($urandom_range(0, 2)) begin w_val = 0; @(negedge clk); end
      w_val = 1; w_data = bd[k]; w_strb = bs[k]; w_last = (k == last_at);
      t = 0;
      while (!w_rdy && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    w_val = 0; w_last = 0;
    chk("b_val_latency", b_val, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic rd_chk(input int w);
    @(negedge clk); rd_addr = 8'(w);
    @(negedge clk); chk($sformatf("mem[%0d]", w), rd_data, mdl[w]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_aw_rdy", aw_rdy, 0); chk("rst_w_rdy", w_rdy, 0); chk("rst_b_val", b_val, 0);
    chk("rst_b_resp", b_resp, 0); chk("rst_b_id", b_id, 0); chk("rst_rd_data", rd_data, 0);
    @(negedge clk); rst = 1; #1;
    chk("aw_rdy_pre_edge", aw_rdy, 0);
    @(negedge clk);
    chk("aw_rdy_after_rst", aw_rdy, 1);

    for (int k = 0; k < 256; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    burst(16'h0000, 8'd255, 2'd1, 4'd0, 255); drain();

    bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
    burst(16'h0010, 8'd0, 2'd1, 4'd3, 0); drain();
    rd_chk(4);

    bd[0] = 32'h11111111; bd[1] = 32'h22222222; bd[2] = 32'h33333333; bd[3] = 32'h44444444;
    bs[0] = 4'h1; bs[1] = 4'h3; bs[2] = 4'hF; bs[3] = 4'h8;
    burst(16'h0020, 8'd3, 2'd1, 4'd1, 3); drain();
    for (int w = 8; w < 12; w++) rd_chk(w);

    for (int k = 0; k < 4; k++) begin bd[k] = 32'hA0A0A000 + k; bs[k] = 4'hF; end
    burst(16'h0038, 8'd3, 2'd2, 4'd2, 3); drain();
    for (int w = 12; w < 16; w++) rd_chk(w);

    for (int k = 0; k < 4; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    burst(16'h0060, 8'd3, 2'd1, 4'd4, 2); drain();

    bd[0] = 32'hCAFE0255; bd[1] = 32'hCAFE0256; bs[0] = 4'hF; bs[1] = 4'hF;
    burst(16'h03FC, 8'd1, 2'd1, 4'd6, 1); drain();
    rd_chk(255);

    b_hold = 1;
    bd[0] = 32'h5A5A5A5A; bs[0] = 4'hF;
    burst(16'h0080, 8'd0, 2'd1, 4'd9, 0);
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_b_val", b_val, 1); chk("stall_aw_rdy", aw_rdy, 0);
    end
    b_hold = 0;
    drain();

    for (int n = 0; n < 30; n++) begin
      logic [1:0] bt;
      logic [7:0] ln;
      int la;
      bt = 2'($urandom_range(0, 3));
      ln = (bt == 2'd2 && $urandom_range(0, 3) != 0) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      la = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16)) : int'(ln);
      for (int k = 0; k <= int'(ln); k++) begin bd[k] = $urandom; bs[k] = 4'($urandom); end
      burst(16'($urandom_range(0, 16'h04FF)), ln, bt, 4'($urandom), la);
      drain();
    end

    @(negedge clk);
    aw_addr = 16'h0100; aw_len = 8'd3; aw_burst = 2'd1; aw_id = 4'd5; aw_val = 1;
    for (int t = 0; t < 20 && !aw_rdy; t++) @(negedge clk);
    chk("rst_test_aw_rdy", aw_rdy, 1);
    @(negedge clk);
    aw_val = 0;
    w_val = 1; w_data = 32'h0BEA7000; w_strb = 4'hF; w_last = 0;
    mdl[64] = 32'h0BEA7000;
    @(negedge clk);
    w_data = 32'h0BEA7001; mdl[65] = 32'h0BEA7001;
    @(negedge clk);
    w_val = 0; rst = 0; #1;
    chk("mid_rst_aw_rdy", aw_rdy, 0); chk("mid_rst_w_rdy", w_rdy, 0); chk("mid_rst_b_val", b_val, 0);
    chk("mid_rst_b_resp", b_resp, 0); chk("mid_rst_b_id", b_id, 0); chk("mid_rst_rd_data", rd_data, 0);
    @(negedge clk); rst = 1; #1;
    chk("mid_rst_aw_rdy_low", aw_rdy, 0);
    @(negedge clk);
    chk("mid_rst_aw_rdy_rise", aw_rdy, 1);

    for (int w = 0; w < 256; w++) rd_chk(w);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
